// File: rtl/vga_sync_gen_if.sv
// Pixel-timing bundle from the VGA sync generator to the font/pixel stages.
interface vga_sync_gen_if;
    logic [9:0] Qh;
    logic [9:0] Qv;
    logic       pix_tick;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       frame_start;
    logic       blink;

    modport master (
        output Qh,
        output Qv,
        output pix_tick,
        output hsync,
        output vsync,
        output video_on,
        output frame_start,
        output blink
    );

    modport slave (
        input Qh,
        input Qv,
        input pix_tick,
        input hsync,
        input vsync,
        input video_on,
        input frame_start,
        input blink
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing source: pixel tick divider, Qh/Qv counters, delayed syncs,
// frame-start pulse and blink flag for the text path.
module vga_sync_gen #(
    parameter int TICK_DIV     = 4,
    parameter int H_VIS        = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_VIS        = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int SYNC_DELAY   = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic           reloj,
    input  logic           resetM,
    vga_sync_gen_if.master vga
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_L = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L = 10'(V_VIS);
    localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC - 1);

    localparam logic [3:0] TICK_LAST = 4'(TICK_DIV - 1);

    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FB_LAST = FW'(BLINK_FRAMES - 1);

    // {hsync, vsync, video_on} with all three inactive
    localparam logic [2:0] SYNC_IDLE = 3'b110;

    logic [3:0]    tick_cnt;
    logic          pix_tick_q;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic          h_last;
    logic          v_last;
    logic          frame_start_q;
    logic [FW-1:0] frame_cnt;
    logic          blink_q;
    logic          hs_raw;
    logic          vs_raw;
    logic          vo_raw;
    logic [2:0]    sync_raw;
    logic [2:0]    sync_out;

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            tick_cnt   <= '0;
            pix_tick_q <= 1'b0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt   <= '0;
            pix_tick_q <= 1'b1;
        end else begin
            tick_cnt   <= tick_cnt + 4'd1;
            pix_tick_q <= 1'b0;
        end
    end

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_tick_q) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Fires on the same edge that wraps both counters back to (0,0)
    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= pix_tick_q && h_last && v_last;
        end
    end

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            frame_cnt <= '0;
            blink_q   <= 1'b0;
        end else if (frame_start_q) begin
            if (frame_cnt == FB_LAST) begin
                frame_cnt <= '0;
                blink_q   <= ~blink_q;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        hs_raw = !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
        vs_raw = !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
        vo_raw = (h_cnt < H_VIS_L) && (v_cnt < V_VIS_L);
    end

    assign sync_raw = {hs_raw, vs_raw, vo_raw};

    // Matches the font stage latency so syncs line up with pixel data
    generate
        if (SYNC_DELAY == 0) begin : g_nodly
            assign sync_out = sync_raw;
        end else begin : g_dly
            logic [2:0] dly [SYNC_DELAY];

            always_ff @(posedge reloj or negedge resetM) begin
                if (!resetM) begin
                    for (int i = 0; i < SYNC_DELAY; i++) begin
                        dly[i] <= SYNC_IDLE;
                    end
                end else begin
                    dly[0] <= sync_raw;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        dly[i] <= dly[i-1];
                    end
                end
            end

            assign sync_out = dly[SYNC_DELAY-1];
        end
    endgenerate

    assign vga.Qh          = h_cnt;
    assign vga.Qv          = v_cnt;
    assign vga.pix_tick    = pix_tick_q;
    assign vga.hsync       = sync_out[2];
    assign vga.vsync       = sync_out[1];
    assign vga.video_on    = sync_out[0];
    assign vga.frame_start = frame_start_q;
    assign vga.blink       = blink_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen using a shrunken 15x8 raster
// (hsync Qh 10..12, vsync Qv 5..6, 480 clocks per frame).
module tb_vga_sync_gen;

    logic reloj = 1'b0;
    logic resetM = 1'b0;

    vga_sync_gen_if vif();

    vga_sync_gen #(
        .TICK_DIV    (4),
        .H_VIS       (8),
        .H_FP        (2),
        .H_SYNC      (3),
        .H_BP        (2),
        .V_VIS       (4),
        .V_FP        (1),
        .V_SYNC      (2),
        .V_BP        (1),
        .SYNC_DELAY  (2),
        .BLINK_FRAMES(2)
    ) dut (
        .reloj (reloj),
        .resetM(resetM),
        .vga   (vif)
    );

    always #5 reloj = ~reloj;

    localparam int S_PIX = 0;
    localparam int S_QH  = 1;
    localparam int S_QV  = 2;
    localparam int S_HS  = 3;
    localparam int S_VS  = 4;
    localparam int S_VO  = 5;
    localparam int S_FS  = 6;
    localparam int S_BL  = 7;

    typedef struct {
        int ph;
        int cyc;
        int sig;
        int exp;
    } exp_t;

    exp_t sb[$];
    int   phase = 1;
    int   cyc;
    int   passed = 0;
    int   total = 0;

    // Edges since the last reset release
    always @(posedge reloj or negedge resetM) begin
        if (!resetM) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    function automatic int sample(int s);
        case (s)
            S_PIX:   return int'(vif.pix_tick);
            S_QH:    return int'(vif.Qh);
            S_QV:    return int'(vif.Qv);
            S_HS:    return int'(vif.hsync);
            S_VS:    return int'(vif.vsync);
            S_VO:    return int'(vif.video_on);
            S_FS:    return int'(vif.frame_start);
            S_BL:    return int'(vif.blink);
            default: return -1;
        endcase
    endfunction

    function automatic string sig_name(int s);
        case (s)
            S_PIX:   return "pix_tick";
            S_QH:    return "Qh";
            S_QV:    return "Qv";
            S_HS:    return "hsync";
            S_VS:    return "vsync";
            S_VO:    return "video_on";
            S_FS:    return "frame_start";
            S_BL:    return "blink";
            default: return "?";
        endcase
    endfunction

    task automatic push(int ph, int c, int s, int e);
        exp_t x;
        x.ph  = ph;
        x.cyc = c;
        x.sig = s;
        x.exp = e;
        sb.push_back(x);
    endtask

    // Monitor: compare every entry due at this cycle of this phase
    initial begin
        exp_t e;
        string nm;
        int act;
        forever begin
            @(negedge reloj);
            while (sb.size() > 0) begin
                e = sb[0];
                nm = $sformatf("%s@p%0d.c%0d", sig_name(e.sig), e.ph, e.cyc);
                if (e.ph == phase && e.cyc == cyc) begin
                    void'(sb.pop_front());
                    act = sample(e.sig);
                    total++;
                    if (act == e.exp) passed++;
                    else $display("FAIL %s: got %0d, expected %0d", nm, act, e.exp);
                end else if (e.ph < phase || (e.ph == phase && e.cyc < cyc)) begin
                    void'(sb.pop_front());
                    total++;
                    $display("FAIL %s: never sampled, expected %0d", nm, e.exp);
                end else begin
                    break;
                end
            end
        end
    end

    task automatic drain(int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge reloj);
            #1;
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            $display("FAIL timeout: got %0d pending entries, expected 0", sb.size());
            total += sb.size();
            sb.delete();
        end
    endtask

    task automatic push_reset_state(int ph);
        push(ph, 0, S_QH, 0);
        push(ph, 0, S_QV, 0);
        push(ph, 0, S_PIX, 0);
        push(ph, 0, S_HS, 1);
        push(ph, 0, S_VS, 1);
        push(ph, 0, S_VO, 0);
        push(ph, 0, S_FS, 0);
        push(ph, 0, S_BL, 0);
    endtask

    initial begin
        resetM = 1'b0;
        phase  = 1;

        push_reset_state(1);
        push(1, 1, S_VO, 0);
        push(1, 1, S_PIX, 0);
        push(1, 2, S_VO, 1);
        push(1, 3, S_PIX, 0);
        push(1, 4, S_PIX, 1);
        push(1, 4, S_QH, 0);
        push(1, 5, S_PIX, 0);
        push(1, 5, S_QH, 1);
        push(1, 7, S_PIX, 0);
        push(1, 8, S_PIX, 1);
        push(1, 9, S_QH, 2);
        push(1, 34, S_VO, 1);
        push(1, 35, S_VO, 0);
        push(1, 42, S_HS, 1);
        push(1, 43, S_HS, 0);
        push(1, 54, S_HS, 0);
        push(1, 55, S_HS, 1);
        push(1, 60, S_QH, 14);
        push(1, 60, S_QV, 0);
        push(1, 61, S_QH, 0);
        push(1, 61, S_QV, 1);
        push(1, 302, S_VS, 1);
        push(1, 303, S_VS, 0);
        push(1, 422, S_VS, 0);
        push(1, 423, S_VS, 1);
        push(1, 480, S_QH, 14);
        push(1, 480, S_QV, 7);
        push(1, 480, S_FS, 0);
        push(1, 481, S_FS, 1);
        push(1, 481, S_QH, 0);
        push(1, 481, S_QV, 0);
        push(1, 482, S_FS, 0);
        push(1, 482, S_BL, 0);
        push(1, 961, S_FS, 1);
        push(1, 961, S_BL, 0);
        push(1, 962, S_BL, 1);
        push(1, 1921, S_BL, 1);
        push(1, 1922, S_BL, 0);
        push(1, 2882, S_BL, 1);
        push(1, 3288, S_QH, 11);
        push(1, 3288, S_QV, 6);
        push(1, 3288, S_HS, 0);
        push(1, 3288, S_VS, 0);
        push(1, 3288, S_VO, 0);

        repeat (3) @(negedge reloj);
        #2 resetM = 1'b1;
        drain(5000);

        // Mid-frame reset while both syncs are low
        #1;
        resetM = 1'b0;
        phase  = 2;
        push_reset_state(2);
        push(2, 2, S_VO, 1);
        push(2, 3, S_PIX, 0);
        push(2, 4, S_PIX, 1);
        push(2, 5, S_QH, 1);
        push(2, 43, S_HS, 0);
        push(2, 61, S_QH, 0);
        push(2, 61, S_QV, 1);

        repeat (3) @(negedge reloj);
        #2 resetM = 1'b1;
        drain(500);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
